// File: rtl/id_wb_pkg.sv
// id_wb_pkg: shared decode types, field positions, NOP controls and the control decoder
package id_wb_pkg;
  typedef enum logic [1:0] {RSEL_ZERO, RSEL_RS, RSEL_RT} rsel_e;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_e;
  localparam int INS_RAW_RS = 21;
  localparam int INS_RAW_RT = 16;
  localparam int INS_REG_W  = 5;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  typedef struct packed {
    rsel_e reg_read1_num;
    rsel_e reg_read2_num;
    alu_e  alu_op;
    logic  reg_write;
    logic  mem_read;
    logic  mem_write;
    logic  branch;
    logic  alu_imm;
  } controls_t;
  localparam int CON_W = $bits(controls_t);
  localparam controls_t CON_NOP = '{RSEL_ZERO, RSEL_ZERO, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  function automatic controls_t control(input logic [31:0] ins);
    controls_t c;
    c = CON_NOP;
    case (ins[31:26])
      OP_RTYPE: begin
        c = '{RSEL_RS, RSEL_RT, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        case (ins[5:0])
          FN_ADDU: c.alu_op = ALU_ADD;
          FN_SUBU: c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_SLT:  c.alu_op = ALU_SLT;
          default: c = CON_NOP;
        endcase
      end
      OP_ADDIU: c = '{RSEL_RS, RSEL_ZERO, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      OP_LW:    c = '{RSEL_RS, RSEL_ZERO, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      OP_SW:    c = '{RSEL_RS, RSEL_RT,   ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      OP_BEQ:   c = '{RSEL_RS, RSEL_RT,   ALU_SUB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      default:  c = CON_NOP;
    endcase
    return c;
  endfunction
  function automatic logic [INS_REG_W-1:0] sel_num(input rsel_e s, input logic [31:0] ins);
    return s == RSEL_RS ? ins[INS_RAW_RS +: INS_REG_W] :
           s == RSEL_RT ? ins[INS_RAW_RT +: INS_REG_W] : '0;
  endfunction
endpackage

// File: rtl/id_wb_stage_regfile_mp.sv
// regfile_mp: multi-write-port register file, r0 hardwired to zero, optional write bypass (ID_WB_BYPASS_EN)
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int WB_PORTS = 2,
  parameter int DBG_A    = 2,
  parameter int DBG_B    = 4
) (
  input  logic                              clk,
  input  logic                              clr_n,
  input  logic [WB_PORTS-1:0]               wb_en,
  input  logic [WB_PORTS*$clog2(NREGS)-1:0] wb_num,
  input  logic [WB_PORTS*XLEN-1:0]          wb_data,
  input  logic [$clog2(NREGS)-1:0]          rd1_num,
  input  logic [$clog2(NREGS)-1:0]          rd2_num,
  output logic [XLEN-1:0]                   rd1_data,
  output logic [XLEN-1:0]                   rd2_data,
  output logic [XLEN-1:0]                   dbg_a,
  output logic [XLEN-1:0]                   dbg_b
);
  localparam int RW = $clog2(NREGS);
  logic [RW-1:0]   w_num  [WB_PORTS];
  logic [XLEN-1:0] w_data [WB_PORTS];
  logic [XLEN-1:0] w_regs [NREGS];
  for (genvar p = 0; p < WB_PORTS; p++) begin : g_port
    assign w_num[p]  = wb_num[p*RW +: RW];
    assign w_data[p] = wb_data[p*XLEN +: XLEN];
  end
  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    logic [XLEN-1:0] r_q;
    // later ports overwrite earlier ones so the highest-index writer wins; r0 never takes a write
    always_ff @(posedge clk or negedge clr_n)
      if (!clr_n) r_q <= '0;
      else for (int p = 0; p < WB_PORTS; p++)
        if (r != 0 && wb_en[p] && w_num[p] == RW'(r)) r_q <= w_data[p];
    assign w_regs[r] = r_q;
  end
  // operand reads, optionally forwarding same-cycle write data (never for r0)
  always_comb begin
    rd1_data = w_regs[rd1_num];
    rd2_data = w_regs[rd2_num];
`ifdef ID_WB_BYPASS_EN
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_en[p] && rd1_num != '0 && w_num[p] == rd1_num) rd1_data = w_data[p];
      if (wb_en[p] && rd2_num != '0 && w_num[p] == rd2_num) rd2_data = w_data[p];
    end
`endif
  end
  assign dbg_a = w_regs[DBG_A];
  assign dbg_b = w_regs[DBG_B];
endmodule

// File: rtl/id_wb_stage.sv
// id_wb_stage: decode + register read + valid/ready pipeline register with multi-port write-back (ID_WB_BYPASS_EN enables write bypass)
module id_wb_stage
  import id_wb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int WB_PORTS = 2,
  parameter int DBG_A    = 2,
  parameter int DBG_B    = 4
) (
  input  logic                              clk,
  input  logic                              clr_n,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [XLEN-1:0]                   in_pc,
  input  logic [31:0]                       in_ins,
  input  logic [WB_PORTS-1:0]               wb_en,
  input  logic [WB_PORTS*$clog2(NREGS)-1:0] wb_num,
  input  logic [WB_PORTS*XLEN-1:0]          wb_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [XLEN-1:0]                   out_pc,
  output logic [31:0]                       out_ins,
  output logic [CON_W-1:0]                  out_controls,
  output logic [XLEN-1:0]                   out_rd1,
  output logic [XLEN-1:0]                   out_rd2,
  output logic [XLEN-1:0]                   dbg_a,
  output logic [XLEN-1:0]                   dbg_b
);
  localparam int RW = $clog2(NREGS);
  controls_t       w_ctl;
  logic [RW-1:0]   w_rn1, w_rn2;
  logic [XLEN-1:0] w_rd1, w_rd2;
  logic            w_load;
  logic            r_valid;
  logic [XLEN-1:0] r_pc, r_rd1, r_rd2;
  logic [31:0]     r_ins;
  controls_t       r_ctl;
  assign w_ctl    = control(in_ins);
  assign w_rn1    = RW'(sel_num(w_ctl.reg_read1_num, in_ins));
  assign w_rn2    = RW'(sel_num(w_ctl.reg_read2_num, in_ins));
  assign in_ready = !r_valid || out_ready;
  assign w_load   = in_valid && in_ready && !flush;
  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .WB_PORTS(WB_PORTS), .DBG_A(DBG_A), .DBG_B(DBG_B)
  ) u_rf (
    .clk(clk), .clr_n(clr_n), .wb_en(wb_en), .wb_num(wb_num), .wb_data(wb_data),
    .rd1_num(w_rn1), .rd2_num(w_rn2), .rd1_data(w_rd1), .rd2_data(w_rd2),
    .dbg_a(dbg_a), .dbg_b(dbg_b)
  );
  // pipeline register: flush squashes to a zeroed bubble and beats a load; drained entries keep their fields
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n || flush) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_ins   <= '0;
      r_ctl   <= CON_NOP;
      r_rd1   <= '0;
      r_rd2   <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_pc    <= in_pc;
      r_ins   <= in_ins;
      r_ctl   <= w_ctl;
      r_rd1   <= w_rd1;
      r_rd2   <= w_rd2;
    end else if (out_ready) r_valid <= 1'b0;
  assign out_valid    = r_valid;
  assign out_pc       = r_pc;
  assign out_ins      = r_ins;
  assign out_controls = r_ctl;
  assign out_rd1      = r_rd1;
  assign out_rd2      = r_rd2;
endmodule

// File: tb/tb_id_wb_stage.sv
// tb_id_wb_stage: randomized and directed checks of id_wb_stage against a behavioural model
module tb_id_wb_stage;
  import id_wb_pkg::*;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int WBP = 2;
  localparam int RW = 5;
  logic clk = 1'b0, clr_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [XLEN-1:0] in_pc = '0;
  logic [31:0] in_ins = '0;
  logic [WBP-1:0] wb_en = '0;
  logic [WBP*RW-1:0] wb_num = '0;
  logic [WBP*XLEN-1:0] wb_data = '0;
  logic in_ready, out_valid;
  logic [XLEN-1:0] out_pc, out_rd1, out_rd2, dbg_a, dbg_b;
  logic [31:0] out_ins;
  logic [CON_W-1:0] out_controls;
  logic [XLEN-1:0] m_regs [NREGS];
  logic m_valid;
  logic [XLEN-1:0] m_pc, m_rd1, m_rd2;
  logic [31:0] m_ins, last_ins, snap;
  logic [CON_W-1:0] m_ctl;
  int n_chk = 0, n_fail = 0;

  id_wb_stage dut (
    .clk(clk), .clr_n(clr_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_ins(in_ins), .wb_en(wb_en), .wb_num(wb_num), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ins(out_ins),
    .out_controls(out_controls), .out_rd1(out_rd1), .out_rd2(out_rd2),
    .dbg_a(dbg_a), .dbg_b(dbg_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_ins(input int k, input logic [4:0] rs, rt, rd, input logic [15:0] imm);
    case (k)
      0: return 32'h0;
      1: return {6'h00, rs, rt, rd, 5'h0, 6'h21};
      2: return {6'h00, rs, rt, rd, 5'h0, 6'h23};
      3: return {6'h09, rs, rt, imm};
      4: return {6'h23, rs, rt, imm};
      5: return {6'h2b, rs, rt, imm};
      6: return {6'h04, rs, rt, imm};
      default: return {6'h3f, rs, rt, imm};
    endcase
  endfunction

  function automatic controls_t exp_ctl(input int k);
    case (k)
      1: return '{RSEL_RS, RSEL_RT,   ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      2: return '{RSEL_RS, RSEL_RT,   ALU_SUB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      3: return '{RSEL_RS, RSEL_ZERO, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      4: return '{RSEL_RS, RSEL_ZERO, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      5: return '{RSEL_RS, RSEL_RT,   ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      6: return '{RSEL_RS, RSEL_RT,   ALU_SUB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      default: return CON_NOP;
    endcase
  endfunction

  function automatic bit uses_rs(input int k);
    return k >= 1 && k <= 6;
  endfunction

  function automatic bit uses_rt(input int k);
    return k == 1 || k == 2 || k == 5 || k == 6;
  endfunction

  function automatic logic [XLEN-1:0] rd_val(input logic [4:0] r, input bit used);
    logic [XLEN-1:0] v;
    if (!used || r == 0) return '0;
    v = m_regs[r];
`ifdef ID_WB_BYPASS_EN
    for (int p = 0; p < WBP; p++)
      if (wb_en[p] && wb_num[p*RW +: RW] == r) v = wb_data[p*XLEN +: XLEN];
`endif
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_valid = 1'b0; m_pc = '0; m_ins = '0; m_ctl = CON_NOP; m_rd1 = '0; m_rd2 = '0;
  endtask

  task automatic step(input int k, input logic [4:0] rs, rt, input bit v, ordy, fl,
                      input logic [1:0] en, input logic [4:0] n0, n1, input logic [31:0] d0, d1);
    logic [31:0] ins, pc;
    logic [XLEN-1:0] e1, e2;
    bit ld;
    ins = mk_ins(k, rs, rt, 5'($urandom), 16'($urandom));
    pc = $urandom;
    in_ins = ins; in_pc = pc; in_valid = v; out_ready = ordy; flush = fl;
    wb_en = en; wb_num = {n1, n0}; wb_data = {d1, d0};
    last_ins = ins;
    #1;
    chk("in_ready", in_ready, !m_valid || ordy);
    e1 = rd_val(rs, uses_rs(k));
    e2 = rd_val(rt, uses_rt(k));
    ld = v && (!m_valid || ordy) && !fl;
    if (fl) begin
      m_valid = 1'b0; m_pc = '0; m_ins = '0; m_ctl = CON_NOP; m_rd1 = '0; m_rd2 = '0;
    end else if (ld) begin
      m_valid = 1'b1; m_pc = pc; m_ins = ins; m_ctl = exp_ctl(k); m_rd1 = e1; m_rd2 = e2;
    end else if (ordy) m_valid = 1'b0;
    if (en[0] && n0 != 0) m_regs[n0] = d0;
    if (en[1] && n1 != 0) m_regs[n1] = d1;
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("out_pc", out_pc, m_pc);
    chk("out_ins", out_ins, m_ins);
    chk("out_controls", out_controls, m_ctl);
    chk("out_rd1", out_rd1, m_rd1);
    chk("out_rd2", out_rd2, m_rd2);
    chk("dbg_a", dbg_a, m_regs[2]);
    chk("dbg_b", dbg_b, m_regs[4]);
  endtask

  initial begin
    m_reset();
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_controls", out_controls, CON_NOP);
    chk("rst_pc", out_pc, 0);
    chk("rst_rd1", out_rd1, 0);
    #11 clr_n = 1'b1;
    @(posedge clk);
    #1;
    // same-register collision: port 1 must win
    step(0, 0, 0, 0, 1, 0, 2'b11, 5, 5, 32'h11, 32'h22);
    step(1, 5, 0, 1, 1, 0, 2'b00, 0, 0, 0, 0);
    chk("collision", out_rd1, 32'h22);
    // same-cycle write and read of r8
    step(1, 8, 0, 1, 1, 0, 2'b01, 8, 0, 32'hDEADBEEF, 0);
`ifdef ID_WB_BYPASS_EN
    chk("bypass", out_rd1, 32'hDEADBEEF);
`else
    chk("bypass", out_rd1, 32'h0);
`endif
    // r0 ignores writes and reads zero, even with a same-cycle write
    step(0, 0, 0, 0, 1, 0, 2'b01, 0, 0, 32'hFFFFFFFF, 0);
    step(1, 0, 0, 1, 1, 0, 2'b10, 0, 0, 0, 32'hFFFFFFFF);
    chk("r0_read", out_rd1, 32'h0);
    // backpressure: three stalled cycles, then resume
    step(3, 5, 0, 1, 1, 0, 2'b00, 0, 0, 0, 0);
    snap = last_ins;
    for (int i = 0; i < 3; i++) step(4, 8, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0);
    chk("bp_hold_ins", out_ins, snap);
    chk("bp_hold_valid", out_valid, 1);
    step(5, 5, 8, 1, 1, 0, 2'b00, 0, 0, 0, 0);
    chk("bp_resume_ins", out_ins, last_ins);
    // flush beats a valid load
    step(1, 5, 8, 1, 1, 0, 2'b00, 0, 0, 0, 0);
    step(6, 5, 8, 1, 1, 1, 2'b00, 0, 0, 0, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_ins", out_ins, 0);
    step(0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0);
    chk("flush_dropped", out_valid, 0);
    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 7), 5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
           2'($urandom), 5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)), $urandom, $urandom);
    // asynchronous reset while holding a valid instruction
    step(1, 2, 4, 1, 1, 0, 2'b11, 2, 4, 32'hAA, 32'hBB);
    step(3, 2, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0);
    chk("pre_rst_valid", out_valid, 1);
    #1 clr_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_controls", out_controls, CON_NOP);
    chk("arst_ins", out_ins, 0);
    chk("arst_dbg_a", dbg_a, 0);
    chk("arst_dbg_b", dbg_b, 0);
    m_reset();
    #2 clr_n = 1'b1;
    step(1, 2, 4, 1, 0, 0, 2'b01, 4, 0, 32'h77, 0);
    for (int i = 0; i < 50; i++)
      step($urandom_range(0, 7), 5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
           2'($urandom), 5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)), $urandom, $urandom);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
